// File: rtl/concat_sequencer_if.sv
// -----------------------------------------------------------------------------
// concat_sequencer_if
// Handshake bundle for concat_sequencer: the frame configuration channel, the
// three upstream source streams, the merged output stream and frame status.
//
//   slave  modport : the sequencer's view (takes cfg/sources, drives output)
//   master modport : the environment's view (drives cfg/sources, sinks output)
// -----------------------------------------------------------------------------
interface concat_sequencer_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 12
);
    logic [COUNT_WIDTH-1:0] i_cfg_count1;
    logic [COUNT_WIDTH-1:0] i_cfg_count2;
    logic [COUNT_WIDTH-1:0] i_cfg_count3;
    logic                   i_cfg_valid;
    logic                   o_cfg_ready;

    logic [DATA_WIDTH-1:0]  i_first_data;
    logic                   i_first_valid;
    logic                   o_first_ready;
    logic [DATA_WIDTH-1:0]  i_second_data;
    logic                   i_second_valid;
    logic                   o_second_ready;
    logic [DATA_WIDTH-1:0]  i_third_data;
    logic                   i_third_valid;
    logic                   o_third_ready;

    logic [DATA_WIDTH-1:0]  o_out_data;
    logic [1:0]             o_out_src;
    logic                   o_out_last;
    logic                   o_out_valid;
    logic                   i_out_ready;

    logic                   o_busy;
    logic                   o_done;

    modport slave (
        input  i_cfg_count1, i_cfg_count2, i_cfg_count3, i_cfg_valid,
        output o_cfg_ready,
        input  i_first_data, i_first_valid,
        output o_first_ready,
        input  i_second_data, i_second_valid,
        output o_second_ready,
        input  i_third_data, i_third_valid,
        output o_third_ready,
        output o_out_data, o_out_src, o_out_last, o_out_valid,
        input  i_out_ready,
        output o_busy, o_done
    );

    modport master (
        output i_cfg_count1, i_cfg_count2, i_cfg_count3, i_cfg_valid,
        input  o_cfg_ready,
        output i_first_data, i_first_valid,
        input  o_first_ready,
        output i_second_data, i_second_valid,
        input  o_second_ready,
        output i_third_data, i_third_valid,
        input  o_third_ready,
        input  o_out_data, o_out_src, o_out_last, o_out_valid,
        output i_out_ready,
        input  o_busy, o_done
    );
endinterface

// File: rtl/concat_sequencer.sv
// -----------------------------------------------------------------------------
// concat_sequencer
// Drains three source streams into one registered output stream, frame by
// frame, in the fixed order source 1 -> 2 -> 3. A configuration handshake
// supplies per-source beat counts; zero-count sources are skipped with no idle
// cycle and source boundaries cost no bubble.
//
// Ports:
//   i_clock   - rising-edge clock
//   i_reset_n - asynchronous active-low reset
//   bus       - concat_sequencer_if.slave: cfg channel, three source streams,
//               output stream (data/src/last/valid/ready), o_busy, o_done
// -----------------------------------------------------------------------------
module concat_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 12
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    concat_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SRC1 = 2'd1,
        SRC2 = 2'd2,
        SRC3 = 2'd3
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ZERO = '0;

    state_t                 state;
    state_t                 state_nxt;
    state_t                 after_sel;   // where to go when the active source empties
    state_t                 cfg_first;   // first non-empty source of a new config
    logic [COUNT_WIDTH-1:0] remaining1;
    logic [COUNT_WIDTH-1:0] remaining2;
    logic [COUNT_WIDTH-1:0] remaining3;
    logic [COUNT_WIDTH-1:0] sel_rem;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic [1:0]             sel_src;
    logic                   load_en;
    logic                   accept;
    logic                   cfg_hs;
    logic                   final_beat;

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        // The output register may take a new beat when empty or draining this cycle.
        load_en            = !bus.o_out_valid || bus.i_out_ready;
        bus.o_first_ready  = (state == SRC1) && load_en;
        bus.o_second_ready = (state == SRC2) && load_en;
        bus.o_third_ready  = (state == SRC3) && load_en;

        accept    = 1'b0;
        sel_data  = '0;
        sel_rem   = COUNT_ZERO;
        sel_src   = 2'd0;
        after_sel = IDLE;
        unique case (state)
            SRC1: begin
                accept    = bus.i_first_valid && bus.o_first_ready;
                sel_data  = bus.i_first_data;
                sel_rem   = remaining1;
                sel_src   = 2'd1;
                after_sel = (remaining2 != COUNT_ZERO) ? SRC2 :
                            (remaining3 != COUNT_ZERO) ? SRC3 : IDLE;
            end
            SRC2: begin
                accept    = bus.i_second_valid && bus.o_second_ready;
                sel_data  = bus.i_second_data;
                sel_rem   = remaining2;
                sel_src   = 2'd2;
                after_sel = (remaining3 != COUNT_ZERO) ? SRC3 : IDLE;
            end
            SRC3: begin
                accept    = bus.i_third_valid && bus.o_third_ready;
                sel_data  = bus.i_third_data;
                sel_rem   = remaining3;
                sel_src   = 2'd3;
                after_sel = IDLE;
            end
            default: ;
        endcase

        // Last beat of the frame: active source empties and nothing follows it.
        final_beat = (sel_rem == COUNT_ONE) && (after_sel == IDLE);

        cfg_hs    = bus.i_cfg_valid && bus.o_cfg_ready;
        cfg_first = (bus.i_cfg_count1 != COUNT_ZERO) ? SRC1 :
                    (bus.i_cfg_count2 != COUNT_ZERO) ? SRC2 :
                    (bus.i_cfg_count3 != COUNT_ZERO) ? SRC3 : IDLE;

        state_nxt = state;
        if (state == IDLE) begin
            if (cfg_hs) state_nxt = cfg_first;
        end else if (accept && (sel_rem == COUNT_ONE)) begin
            state_nxt = after_sel;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state           <= IDLE;
            remaining1      <= COUNT_ZERO;
            remaining2      <= COUNT_ZERO;
            remaining3      <= COUNT_ZERO;
            bus.o_out_data  <= '0;
            bus.o_out_src   <= 2'd0;
            bus.o_out_last  <= 1'b0;
            bus.o_out_valid <= 1'b0;
            bus.o_cfg_ready <= 1'b1;
            bus.o_busy      <= 1'b0;
            bus.o_done      <= 1'b0;
        end else begin
            state           <= state_nxt;
            bus.o_cfg_ready <= (state_nxt == IDLE);
            bus.o_busy      <= (state_nxt != IDLE);

            // Completion: the last beat leaves, or an all-zero frame is accepted.
            bus.o_done <= (bus.o_out_valid && bus.i_out_ready && bus.o_out_last) ||
                          (cfg_hs && (cfg_first == IDLE));

            if (load_en) begin
                bus.o_out_valid <= accept;
                if (accept) begin
                    bus.o_out_data <= sel_data;
                    bus.o_out_src  <= sel_src;
                    bus.o_out_last <= final_beat;
                end
            end

            if (cfg_hs) begin
                remaining1 <= bus.i_cfg_count1;
                remaining2 <= bus.i_cfg_count2;
                remaining3 <= bus.i_cfg_count3;
            end else if (accept) begin
                unique case (state)
                    SRC1: if (remaining1 != COUNT_ZERO) remaining1 <= remaining1 - COUNT_ONE;
                    SRC2: if (remaining2 != COUNT_ZERO) remaining2 <= remaining2 - COUNT_ONE;
                    SRC3: if (remaining3 != COUNT_ZERO) remaining3 <= remaining3 - COUNT_ONE;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_concat_sequencer.sv
// -----------------------------------------------------------------------------
// tb_concat_sequencer
// Directed bench for concat_sequencer. Each source emits {src, running index}
// so expected output data follows from the bench's own per-source counters.
// -----------------------------------------------------------------------------
module tb_concat_sequencer;

    localparam int DW = 8;
    localparam int CW = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    concat_sequencer_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus ();

    concat_sequencer #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    typedef struct {
        int src;
        int data;
        bit last;
        int cyc;
    } beat_t;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    logic [31:0] cnt1 = 0, cnt2 = 0, cnt3 = 0;
    beat_t beats[$];
    int    done_q[$];
    int    hs_q[$];
    int    r1_cnt = 0, r2_cnt = 0, r3_cnt = 0;
    int    stall_bad = 0;
    logic  prev_v = 1'b0, prev_r = 1'b0, prev_last = 1'b0;
    logic [DW-1:0] prev_d = '0;
    logic [1:0]    prev_s = '0;

    assign bus.i_first_data  = {2'd1, cnt1[5:0]};
    assign bus.i_second_data = {2'd2, cnt2[5:0]};
    assign bus.i_third_data  = {2'd3, cnt3[5:0]};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.i_first_valid  && bus.o_first_ready)  cnt1 <= cnt1 + 1;
        if (bus.i_second_valid && bus.o_second_ready) cnt2 <= cnt2 + 1;
        if (bus.i_third_valid  && bus.o_third_ready)  cnt3 <= cnt3 + 1;
    end

    // Observe handshakes mid-cycle; each one completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (bus.o_out_valid && bus.i_out_ready)
                beats.push_back('{int'(bus.o_out_src), int'(bus.o_out_data), bus.o_out_last, cyc});
            if (bus.o_done) done_q.push_back(cyc);
            if (bus.i_cfg_valid && bus.o_cfg_ready) hs_q.push_back(cyc);
            if (bus.o_first_ready)  r1_cnt++;
            if (bus.o_second_ready) r2_cnt++;
            if (bus.o_third_ready)  r3_cnt++;
            if (prev_v && !prev_r &&
                !(bus.o_out_valid && bus.o_out_data == prev_d &&
                  bus.o_out_src == prev_s && bus.o_out_last == prev_last))
                stall_bad++;
            prev_v    = bus.o_out_valid;
            prev_r    = bus.i_out_ready;
            prev_d    = bus.o_out_data;
            prev_s    = bus.o_out_src;
            prev_last = bus.o_out_last;
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Present a configuration until it is accepted (bounded), then withdraw it.
    task automatic run_cfg(input int c1, input int c2, input int c3);
        int h0;
        h0 = hs_q.size();
        bus.i_cfg_count1 = CW'(c1);
        bus.i_cfg_count2 = CW'(c2);
        bus.i_cfg_count3 = CW'(c3);
        bus.i_cfg_valid  = 1'b1;
        for (int i = 0; i < 50 && hs_q.size() == h0; i++) step();
        bus.i_cfg_valid = 1'b0;
        check("cfg_accepted", hs_q.size() - h0, 1);
    endtask

    task automatic wait_beats(input int base, input int n, input int budget);
        for (int i = 0; i < budget && beats.size() - base < n; i++) step();
        check("beats_arrived", beats.size() - base, n);
    endtask

    // Compare captured beats against reps back-to-back frames of (c1,c2,c3).
    task automatic verify(input int base, input int s1, input int s2, input int s3,
                          input int c1, input int c2, input int c3,
                          input int reps, input bit contig);
        int idx, n1, n2, n3, last_k, k, cnt, n, fstart;
        idx = base; n1 = s1; n2 = s2; n3 = s3;
        last_k = (c3 != 0) ? 3 : (c2 != 0) ? 2 : 1;
        check("beat_count", beats.size() - base, reps * (c1 + c2 + c3));
        if (beats.size() - base < reps * (c1 + c2 + c3)) return;
        for (int r = 0; r < reps; r++) begin
            fstart = idx;
            for (int kk = 1; kk <= 3; kk++) begin
                k   = kk;
                cnt = (k == 1) ? c1 : (k == 2) ? c2 : c3;
                for (int i = 0; i < cnt; i++) begin
                    n = (k == 1) ? n1 : (k == 2) ? n2 : n3;
                    check("beat_src",  beats[idx].src, k);
                    check("beat_data", beats[idx].data, k * 64 + (n % 64));
                    check("beat_last", beats[idx].last, (k == last_k) && (i == cnt - 1));
                    if (contig) check("no_bubble", beats[idx].cyc, beats[fstart].cyc + (idx - fstart));
                    if (k == 1) n1++; else if (k == 2) n2++; else n3++;
                    idx++;
                end
            end
        end
    endtask

    task automatic check_done(input int d0, input int last_cyc);
        for (int i = 0; i < 3; i++) step();
        check("done_count", done_q.size() - d0, 1);
        if (done_q.size() > d0) check("done_timing", done_q[d0], last_cyc + 1);
    endtask

    initial begin
        int b0, d0, a1, a2, a3, q1, q3, sb0, h0;

        bus.i_cfg_count1   = '0;
        bus.i_cfg_count2   = '0;
        bus.i_cfg_count3   = '0;
        bus.i_cfg_valid    = 1'b0;
        bus.i_first_valid  = 1'b1;
        bus.i_second_valid = 1'b1;
        bus.i_third_valid  = 1'b1;
        bus.i_out_ready    = 1'b1;

        // Reset state.
        #12;
        check("rst_cfg_ready", bus.o_cfg_ready, 1);
        check("rst_out_valid", bus.o_out_valid, 0);
        check("rst_busy",      bus.o_busy, 0);
        check("rst_done",      bus.o_done, 0);
        check("rst_ready1",    bus.o_first_ready, 0);
        #13 rst_n = 1'b1;
        step();

        // (3,2,1) with a ready sink: six contiguous beats then o_done.
        b0 = beats.size(); d0 = done_q.size();
        a1 = cnt1; a2 = cnt2; a3 = cnt3;
        run_cfg(3, 2, 1);
        check("busy_in_frame", bus.o_busy, 1);
        check("cfg_ready_in_frame", bus.o_cfg_ready, 0);
        wait_beats(b0, 6, 40);
        verify(b0, a1, a2, a3, 3, 2, 1, 1, 1'b1);
        if (beats.size() >= b0 + 6) check_done(d0, beats[b0 + 5].cyc);

        // (0,4,0): only source 2 is ever readied.
        b0 = beats.size(); d0 = done_q.size();
        a1 = cnt1; a2 = cnt2; a3 = cnt3; q1 = r1_cnt; q3 = r3_cnt;
        run_cfg(0, 4, 0);
        wait_beats(b0, 4, 40);
        verify(b0, a1, a2, a3, 0, 4, 0, 1, 1'b1);
        if (beats.size() >= b0 + 4) check_done(d0, beats[b0 + 3].cyc);
        check("ready1_never", r1_cnt - q1, 0);
        check("ready3_never", r3_cnt - q3, 0);

        // (0,0,0): no beats, o_done right after the handshake, never busy.
        b0 = beats.size();
        run_cfg(0, 0, 0);
        check("zero_done_pulse", bus.o_done, 1);
        check("zero_busy",       bus.o_busy, 0);
        check("zero_cfg_ready",  bus.o_cfg_ready, 1);
        step();
        check("zero_done_clear", bus.o_done, 0);
        for (int i = 0; i < 4; i++) step();
        check("zero_no_beats", beats.size() - b0, 0);

        // (2,2,2) with the sink alternating ready/stall.
        b0 = beats.size(); d0 = done_q.size(); sb0 = stall_bad;
        a1 = cnt1; a2 = cnt2; a3 = cnt3;
        run_cfg(2, 2, 2);
        for (int i = 0; i < 60 && beats.size() - b0 < 6; i++) begin
            bus.i_out_ready = ~bus.i_out_ready;
            step();
        end
        bus.i_out_ready = 1'b1;
        verify(b0, a1, a2, a3, 2, 2, 2, 1, 1'b0);
        check("stall_hold", stall_bad - sb0, 0);
        if (beats.size() >= b0 + 6) check_done(d0, beats[b0 + 5].cyc);

        // (5,5,5) interrupted by reset after seven output beats.
        b0 = beats.size();
        run_cfg(5, 5, 5);
        wait_beats(b0, 7, 40);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid",     bus.o_out_valid, 0);
        check("mid_rst_data",      bus.o_out_data, 0);
        check("mid_rst_src",       bus.o_out_src, 0);
        check("mid_rst_last",      bus.o_out_last, 0);
        check("mid_rst_busy",      bus.o_busy, 0);
        check("mid_rst_done",      bus.o_done, 0);
        check("mid_rst_ready2",    bus.o_second_ready, 0);
        check("mid_rst_cfg_ready", bus.o_cfg_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        d0 = done_q.size();
        step(); step();
        check("post_rst_no_done", done_q.size() - d0, 0);
        check("post_rst_cfg_ready", bus.o_cfg_ready, 1);
        b0 = beats.size(); d0 = done_q.size();
        a1 = cnt1; a2 = cnt2; a3 = cnt3;
        run_cfg(1, 1, 1);
        wait_beats(b0, 3, 30);
        verify(b0, a1, a2, a3, 1, 1, 1, 1, 1'b1);
        if (beats.size() >= b0 + 3) check_done(d0, beats[b0 + 2].cyc);

        // i_cfg_valid held high: the second config waits for IDLE.
        b0 = beats.size(); h0 = hs_q.size();
        a1 = cnt1; a2 = cnt2; a3 = cnt3;
        bus.i_cfg_count1 = CW'(2);
        bus.i_cfg_count2 = CW'(1);
        bus.i_cfg_count3 = CW'(1);
        bus.i_cfg_valid  = 1'b1;
        for (int i = 0; i < 60 && hs_q.size() - h0 < 2; i++) step();
        bus.i_cfg_valid = 1'b0;
        check("held_cfg_hs", hs_q.size() - h0, 2);
        wait_beats(b0, 8, 60);
        verify(b0, a1, a2, a3, 2, 1, 1, 2, 1'b0);
        if (beats.size() >= b0 + 4 && hs_q.size() >= h0 + 2)
            check("second_cfg_after_last", hs_q[h0 + 1] >= beats[b0 + 3].cyc, 1);
        for (int i = 0; i < 4; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/concat_sequencer.md
Name: concat_sequencer

Overview:
- Frame-level scheduler that drains three upstream streams into one shared output stream, in fixed order: source 1, then source 2, then source 3.
- Each frame is started by a configuration handshake carrying per-source beat counts.
- The block sits between the three per-source buffers and the downstream framer. It provides one registered output stage, full throughput and no inter-source bubbles.

Parameters:
DATA_WIDTH, 8, width of every input stream and of the output stream
COUNT_WIDTH, 12, width of per-source beat counts (max 4095 beats per source per frame)

Ports:
i_clock  input  1  sole clock, rising edge
i_reset_n  input  1  asynchronous, active-low reset
i_cfg_count1  input  COUNT_WIDTH  beats to take from source 1 this frame
i_cfg_count2  input  COUNT_WIDTH  beats to take from source 2 this frame
i_cfg_count3  input  COUNT_WIDTH  beats to take from source 3 this frame
i_cfg_valid  input  1  frame configuration valid
o_cfg_ready  output  1  configuration accepted when high with i_cfg_valid
i_first_data  input  DATA_WIDTH  source 1 data
i_first_valid  input  1  source 1 valid
o_first_ready  output  1  source 1 ready
i_second_data  input  DATA_WIDTH  source 2 data
i_second_valid  input  1  source 2 valid
o_second_ready  output  1  source 2 ready
i_third_data  input  DATA_WIDTH  source 3 data
i_third_valid  input  1  source 3 valid
o_third_ready  output  1  source 3 ready
o_out_data  output  DATA_WIDTH  output data (registered)
o_out_src  output  2  source of current output beat: 1, 2 or 3
o_out_last  output  1  final beat of frame
o_out_valid  output  1  output valid
i_out_ready  input  1  downstream ready
o_busy  output  1  frame in progress (state != IDLE)
o_done  output  1  one-cycle pulse when the frame is complete

Behaviour:

Reset:
- Asynchronous assert on i_reset_n low; synchronous release.
- State goes to IDLE.
- All outputs are 0 except o_cfg_ready, which is 1 after reset.
- Reset mid-frame discards remaining counts and any beat held in the output register; no o_done is produced.

States: IDLE, SRC1, SRC2, SRC3.
- IDLE:
  - o_cfg_ready=1.
  - On cfg handshake, counts are latched into remaining1..3.
  - Next state is the first source with a nonzero count.
  - If all three counts are 0: stay IDLE and pulse o_done the next cycle; no output beat is produced.
- SRCk:
  - o_cfg_ready=0; i_cfg_valid is ignored.
  - Only o_k_ready may be high; the other two readies are 0.
- Leaving SRCk: the beat that takes remaining_k from 1 to 0 moves the state, in the same cycle, to the next source j>k with nonzero count. If there is none, the state returns to IDLE.
- Zero-count sources are skipped with no idle cycle.

Handshake rules:
- Load enable: load_en = !o_out_valid || i_out_ready.
- o_k_ready = (state==SRCk) && load_en. It is combinational from i_out_ready.
- Accept on i_k_valid && o_k_ready:
  - Next cycle: o_out_data=data, o_out_src=k, o_out_valid=1.
  - remaining_k decrements.
  - o_out_last=1 iff this is the final beat of the frame.
- Output register: when o_out_valid && !i_out_ready, data, src and last hold stable.
- When load_en is high and nothing is accepted, o_out_valid goes to 0 on the next edge.

Latency and throughput:
- Input accept at cycle t gives output valid at t+1.
- Sustained throughput is one beat per cycle, including across source boundaries.

Frame completion:
- o_done pulses for one cycle, in the cycle after the o_out_last beat handshakes out.
- A new configuration may be accepted once IDLE is re-entered, even while the last beat is still held. Its first beat enters the output register only after the held beat leaves.

Arithmetic:
- Counters are unsigned COUNT_WIDTH bits and never wrap; decrement happens only when the count is nonzero.

Test Plan:
- Counts (3,2,1), all sources always valid, i_out_ready=1 -> 6 consecutive output beats; o_out_src=1,1,1,2,2,3; o_out_last only on beat 6; o_done one cycle later; no bubbles.
- Counts (0,4,0) -> only source 2 is ever readied; 4 beats with o_out_src=2; o_out_last on beat 4; o_first_ready and o_third_ready never high.
- Counts (0,0,0) -> no output beats; o_done pulses at t+1 after the cfg handshake; o_busy stays 0.
- Counts (2,2,2) with i_out_ready toggling 1,0,1,0 -> o_out_data stable while stalled; exactly 6 beats in order; no drop or duplicate.
- Counts (5,5,5), i_reset_n low after 7 output beats -> all outputs 0 immediately; o_cfg_ready=1 after release; a new frame (1,1,1) runs cleanly with 3 beats.
- i_cfg_valid held high during a frame -> second config is accepted only after IDLE is re-entered; its beats follow the first frame's last beat without loss.
